mem_access_ctrl: RTL and testbench

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mem_ctrl_pkg.sv | 22 ++
 rtl/mem_access_ctrl_if.sv | 15 +
 rtl/mem_access_ctrl_wait_timer.sv | 32 +++
 rtl/mem_access_ctrl.sv | 117 +++++++++++
 tb/tb_mem_access_ctrl.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the data-memory access controller.
package mem_ctrl_pkg;

   localparam int unsigned ADDR_W                 = 32;
   localparam int unsigned DATA_W                 = 32;
   localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 255;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_DONE = 2'd2,
      S_ERR  = 2'd3
   } state_t;

   // Request payload latched when a memory op leaves EX/MEM.
   typedef struct packed {
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } dmem_cmd_t;

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Data-memory request/acknowledge bus between the controller and the memory.
interface mem_access_ctrl_if;
   import mem_ctrl_pkg::*;

   logic              req;
   logic              we;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic              ack;
   logic [DATA_W-1:0] rdata;

   modport master (output req, we, addr, wdata, input  ack, rdata);
   modport slave  (input  req, we, addr, wdata, output ack, rdata);

endinterface

// File: rtl/mem_access_ctrl_wait_timer.sv
// Saturating wait-cycle counter; expired flags the cycle in which the count reaches the limit.
module wait_timer
   import mem_ctrl_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int unsigned      CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

   logic [CNT_W-1:0] count;

   // Clear wins over enable; the count holds at LIMIT instead of wrapping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable && (count != LIMIT)) begin
         count <= count + CNT_W'(1);
      end
   end

   assign expired = enable && (count == (LIMIT - CNT_W'(1)));

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage controller: issues one data-memory transaction per load/store and stalls the pipeline until it completes.
module mem_access_ctrl
   import mem_ctrl_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               instr_valid_in,
   input  logic               mem_read_in,
   input  logic               mem_write_in,
   input  logic [ADDR_W-1:0]  addr_in,
   input  logic [DATA_W-1:0]  wdata_in,
   mem_access_ctrl_if.master  dmem,
   output logic               stall_out,
   output logic               wb_valid_out,
   output logic [DATA_W-1:0]  rdata_out,
   output logic               timeout_err
);

   state_t    state;
   state_t    next_state;
   dmem_cmd_t cmd;
   logic      req;
   logic      mem_op_c;
   logic      timer_clear;
   logic      timer_en;
   logic      timer_expired;

   assign mem_op_c = instr_valid_in && (mem_read_in || mem_write_in);

   wait_timer #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_wait_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (timer_clear),
      .enable  (timer_en),
      .expired (timer_expired)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next state; stall and wb_valid are decoded combinationally so a
   // non-memory instruction passes with zero added latency.
   always_comb begin
      next_state   = state;
      stall_out    = 1'b0;
      wb_valid_out = 1'b0;
      timer_clear  = 1'b0;
      timer_en     = 1'b0;
      case (state)
         S_IDLE: begin
            if (mem_op_c) begin
               stall_out   = 1'b1;
               timer_clear = 1'b1;
               next_state  = S_WAIT;
            end else begin
               wb_valid_out = instr_valid_in;
            end
         end
         S_WAIT: begin
            stall_out = 1'b1;
            timer_en  = 1'b1;
            if (dmem.ack) begin
               next_state = S_DONE;
            end else if (timer_expired) begin
               next_state = S_ERR;
            end
         end
         S_DONE: begin
            wb_valid_out = 1'b1;
            next_state   = S_IDLE;
         end
         S_ERR: begin
            stall_out = 1'b1;
         end
         default: begin
            next_state = S_IDLE;
         end
      endcase
   end

   // Request, command, load data and sticky error registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         req         <= 1'b0;
         cmd         <= '0;
         rdata_out   <= '0;
         timeout_err <= 1'b0;
      end else begin
         req <= (next_state == S_WAIT);
         if ((state == S_IDLE) && mem_op_c) begin
            cmd <= '{we: mem_write_in, addr: addr_in, wdata: wdata_in};
         end
         if ((state == S_WAIT) && dmem.ack && !cmd.we) begin
            rdata_out <= dmem.rdata;
         end
         if (next_state == S_ERR) begin
            timeout_err <= 1'b1;
         end
      end
   end

   assign dmem.req   = req;
   assign dmem.we    = cmd.we;
   assign dmem.addr  = cmd.addr;
   assign dmem.wdata = cmd.wdata;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: default-timeout instance plus a TIMEOUT_CYCLES=4 instance.
module tb_mem_access_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        rst4_n;
   logic        instr_valid;
   logic        mem_read;
   logic        mem_write;
   logic [31:0] addr;
   logic [31:0] wdata;

   logic        stall,  wb_valid,  terr;
   logic [31:0] rdata_out;
   logic        stall4, wb_valid4, terr4;
   logic [31:0] rdata_out4;

   int unsigned total  = 0;
   int unsigned passed = 0;

   mem_access_ctrl_if dmem  ();
   mem_access_ctrl_if dmem4 ();

   always #5 clk = ~clk;

   mem_access_ctrl u_dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .instr_valid_in (instr_valid),
      .mem_read_in    (mem_read),
      .mem_write_in   (mem_write),
      .addr_in        (addr),
      .wdata_in       (wdata),
      .dmem           (dmem.master),
      .stall_out      (stall),
      .wb_valid_out   (wb_valid),
      .rdata_out      (rdata_out),
      .timeout_err    (terr)
   );

   mem_access_ctrl #(
      .TIMEOUT_CYCLES (4)
   ) u_dut4 (
      .clk            (clk),
      .rst_n          (rst4_n),
      .instr_valid_in (instr_valid),
      .mem_read_in    (mem_read),
      .mem_write_in   (mem_write),
      .addr_in        (addr),
      .wdata_in       (wdata),
      .dmem           (dmem4.master),
      .stall_out      (stall4),
      .wb_valid_out   (wb_valid4),
      .rdata_out      (rdata_out4),
      .timeout_err    (terr4)
   );

   task automatic chk1(input string tag, input logic obs, input logic exp_v);
      total++;
      assert (obs === exp_v) passed++;
      else $error("FAIL %s: observed %b expected %b", tag, obs, exp_v);
   endtask

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      total++;
      assert (obs === exp_v) passed++;
      else $error("FAIL %s: observed %08h expected %08h", tag, obs, exp_v);
   endtask

   // Drive new inputs just after a rising edge, then move to mid-cycle for checking.
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   task automatic drive(input logic v, input logic r, input logic w,
                        input logic [31:0] a, input logic [31:0] d);
      instr_valid = v;
      mem_read    = r;
      mem_write   = w;
      addr        = a;
      wdata       = d;
   endtask

   initial begin
      rst_n  = 1'b0;
      rst4_n = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      dmem.ack    = 1'b0;
      dmem.rdata  = 32'h0;
      dmem4.ack   = 1'b0;
      dmem4.rdata = 32'h0;

      // Reset values
      #2;
      chk1 ("rst_req",   dmem.req,   1'b0);
      chk1 ("rst_we",    dmem.we,    1'b0);
      chk32("rst_addr",  dmem.addr,  32'h0);
      chk32("rst_wdata", dmem.wdata, 32'h0);
      chk32("rst_rdata", rdata_out,  32'h0);
      chk1 ("rst_terr",  terr,       1'b0);
      chk1 ("rst_stall", stall,      1'b0);
      chk1 ("rst_wbv",   wb_valid,   1'b0);
      mid();
      rst_n  = 1'b1;
      rst4_n = 1'b1;

      // Idle, no instruction
      next_cycle(); mid();
      chk1("idle_stall", stall,    1'b0);
      chk1("idle_wbv",   wb_valid, 1'b0);

      // ADD, ADD, LW 0x40 with ack on first WAIT cycle
      next_cycle(); drive(1'b1, 1'b0, 1'b0, 32'h0000_0099, 32'h0); mid();
      chk1("add1_stall", stall,    1'b0);
      chk1("add1_wbv",   wb_valid, 1'b1);
      chk1("add1_req",   dmem.req, 1'b0);
      next_cycle(); drive(1'b1, 1'b0, 1'b0, 32'h0000_0098, 32'h0); mid();
      chk1("add2_stall", stall,    1'b0);
      chk1("add2_wbv",   wb_valid, 1'b1);
      next_cycle(); drive(1'b1, 1'b1, 1'b0, 32'h0000_0040, 32'h0); mid();
      chk1("lw_idle_stall", stall,    1'b1);
      chk1("lw_idle_wbv",   wb_valid, 1'b0);
      chk1("lw_idle_req",   dmem.req, 1'b0);
      next_cycle(); dmem.ack = 1'b1; dmem.rdata = 32'hDEAD_BEEF; mid();
      chk1 ("lw_wait_req",   dmem.req,  1'b1);
      chk1 ("lw_wait_we",    dmem.we,   1'b0);
      chk32("lw_wait_addr",  dmem.addr, 32'h0000_0040);
      chk1 ("lw_wait_stall", stall,     1'b1);
      chk1 ("lw_wait_wbv",   wb_valid,  1'b0);
      next_cycle(); dmem.ack = 1'b0; dmem.rdata = 32'h0; drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0); mid();
      chk1 ("lw_done_req",   dmem.req,  1'b0);
      chk1 ("lw_done_stall", stall,     1'b0);
      chk1 ("lw_done_wbv",   wb_valid,  1'b1);
      chk32("lw_done_rdata", rdata_out, 32'hDEAD_BEEF);
      next_cycle(); mid();
      chk1("lw_after_wbv", wb_valid, 1'b0);

      // Ack outside WAIT is ignored
      next_cycle(); dmem.ack = 1'b1; dmem.rdata = 32'h5555_5555; mid();
      next_cycle(); dmem.ack = 1'b0; mid();
      chk1 ("ack_idle_stall", stall,     1'b0);
      chk1 ("ack_idle_req",   dmem.req,  1'b0);
      chk32("ack_idle_rdata", rdata_out, 32'hDEAD_BEEF);

      // Store 0x10 / 0x12345678, ack in fifth WAIT cycle; EX/MEM inputs wiggled to prove outputs hold
      next_cycle(); drive(1'b1, 1'b0, 1'b1, 32'h0000_0010, 32'h1234_5678); mid();
      chk1("sw_idle_stall", stall, 1'b1);
      for (int k = 1; k <= 5; k++) begin
         next_cycle();
         drive(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
         dmem.ack   = (k == 5);
         dmem.rdata = 32'hAAAA_AAAA;
         mid();
         chk1 ($sformatf("sw_w%0d_req",   k), dmem.req,   1'b1);
         chk1 ($sformatf("sw_w%0d_we",    k), dmem.we,    1'b1);
         chk32($sformatf("sw_w%0d_addr",  k), dmem.addr,  32'h0000_0010);
         chk32($sformatf("sw_w%0d_wdata", k), dmem.wdata, 32'h1234_5678);
         chk1 ($sformatf("sw_w%0d_stall", k), stall,      1'b1);
         chk1 ($sformatf("sw_w%0d_wbv",   k), wb_valid,   1'b0);
      end
      next_cycle(); dmem.ack = 1'b0; drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0); mid();
      chk1 ("sw_done_req",   dmem.req,  1'b0);
      chk1 ("sw_done_stall", stall,     1'b0);
      chk1 ("sw_done_wbv",   wb_valid,  1'b1);
      chk32("sw_done_rdata", rdata_out, 32'hDEAD_BEEF);

      // Read and write together execute as a write
      next_cycle(); drive(1'b1, 1'b1, 1'b1, 32'h0000_0020, 32'h0000_0077); mid();
      next_cycle(); dmem.ack = 1'b1; dmem.rdata = 32'hBBBB_BBBB; mid();
      chk1("rw_we", dmem.we, 1'b1);
      next_cycle(); dmem.ack = 1'b0; drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0); mid();
      chk32("rw_rdata", rdata_out, 32'hDEAD_BEEF);

      // Reset mid-WAIT drops the request immediately
      next_cycle(); drive(1'b1, 1'b1, 1'b0, 32'h0000_0080, 32'h0); mid();
      next_cycle(); mid();
      chk1("rstw_req_before", dmem.req, 1'b1);
      #1 rst_n = 1'b0;
      #1;
      chk1 ("rstw_req_now", dmem.req,  1'b0);
      chk32("rstw_addr",    dmem.addr, 32'h0);
      chk32("rstw_rdata",   rdata_out, 32'h0);
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      #1 rst_n = 1'b1;
      next_cycle(); mid();
      chk1("rstw_idle_stall", stall,    1'b0);
      chk1("rstw_idle_req",   dmem.req, 1'b0);
      next_cycle(); drive(1'b1, 1'b1, 1'b0, 32'h0000_0044, 32'h0); mid();
      next_cycle(); dmem.ack = 1'b1; dmem.rdata = 32'hCAFE_F00D; mid();
      chk32("rstw_lw_addr", dmem.addr, 32'h0000_0044);
      next_cycle(); dmem.ack = 1'b0; drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0); mid();
      chk1 ("rstw_lw_wbv",   wb_valid,  1'b1);
      chk32("rstw_lw_rdata", rdata_out, 32'hCAFE_F00D);

      // TIMEOUT_CYCLES=4 instance: no ack leads to ERR after four WAIT cycles
      #1 rst4_n = 1'b0;
      #1 rst4_n = 1'b1;
      next_cycle(); drive(1'b1, 1'b1, 1'b0, 32'h0000_0100, 32'h0); mid();
      for (int k = 1; k <= 4; k++) begin
         next_cycle(); mid();
         chk1($sformatf("to_w%0d_req",  k), dmem4.req, 1'b1);
         chk1($sformatf("to_w%0d_terr", k), terr4,     1'b0);
      end
      next_cycle(); mid();
      chk1("to_err_req",   dmem4.req, 1'b0);
      chk1("to_err_terr",  terr4,     1'b1);
      chk1("to_err_stall", stall4,    1'b1);
      chk1("to_err_wbv",   wb_valid4, 1'b0);
      next_cycle(); dmem4.ack = 1'b1; drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0); mid();
      next_cycle(); dmem4.ack = 1'b0; mid();
      chk1("to_sticky_terr",  terr4,  1'b1);
      chk1("to_sticky_stall", stall4, 1'b1);
      #1 rst4_n = 1'b0;
      #1;
      chk1("to_rst_terr", terr4, 1'b0);
      #1 rst4_n = 1'b1;

      // Ack in the fourth WAIT cycle wins over the timeout
      next_cycle(); drive(1'b1, 1'b1, 1'b0, 32'h0000_0104, 32'h0); mid();
      for (int k = 1; k <= 4; k++) begin
         next_cycle();
         dmem4.ack   = (k == 4);
         dmem4.rdata = 32'h0BAD_F00D;
         mid();
      end
      next_cycle(); dmem4.ack = 1'b0; drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0); mid();
      chk1 ("ack4_done_terr",  terr4,      1'b0);
      chk1 ("ack4_done_wbv",   wb_valid4,  1'b1);
      chk1 ("ack4_done_stall", stall4,     1'b0);
      chk32("ack4_done_rdata", rdata_out4, 32'h0BAD_F00D);
      next_cycle(); mid();
      chk1("ack4_idle_terr", terr4, 1'b0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
